// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - EX-stage ALU with valid/ready handshake and bit-serial divider
// Optional RV32M support (MUL/MULH*/DIV*/REM*) is compiled in when MEXT_EN is defined.
module alu_exec_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [1:0]      AluOp,
  input  logic [2:0]      Fn3,
  input  logic            Fn7b5,
  input  logic            Fn7b0,
  input  logic            LastBit,
  input  logic [XLEN-1:0] OpA,
  input  logic [XLEN-1:0] OpB,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_DONE, S_DIV, S_FIX} state_t;

  state_t                 state_q, state_d;
  logic [XLEN-1:0]        result_q, result_d;
  logic [SHW-1:0]         cnt_q, cnt_d;
  logic                   accept;
  logic                   f7b5_eff;
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] sra_res;
  logic [XLEN-1:0]        base_res;
  logic [XLEN-1:0]        alu_res;

  // Immediate forms carry imm bits in funct7, so only SRAI keeps bit 5.
  assign f7b5_eff = Fn7b5 & (~LastBit | (Fn3 == 3'b101));
  assign shamt    = OpB[SHW-1:0];
  assign sra_res  = $signed(OpA) >>> shamt;

  assign InReady  = (state_q == S_IDLE) | ((state_q == S_DONE) & OutReady);
  assign accept   = InValid & InReady & ~Flush;
  assign OutValid = (state_q == S_DONE);
  assign Result   = result_q;
  assign Zero     = (result_q == '0);

`ifdef MEXT_EN
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic              m_sel, div_sel, div_signed, div_by_zero, div_ovf;
  logic [XLEN-1:0]   mul_res, abs_a, abs_b, short_res, min_val;
  logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic              neg_q_q, neg_q_d, neg_r_q, neg_r_d, is_rem_q, is_rem_d;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign m_sel      = Fn7b0 & ~LastBit & (AluOp == 2'b10);
  assign div_sel    = m_sel & Fn3[2];
  // Single 2*XLEN multiplier; operand extension selects signed/unsigned halves.
  assign mul_a      = (Fn3[1:0] == 2'b11) ? {{XLEN{1'b0}}, OpA} : {{XLEN{OpA[XLEN-1]}}, OpA};
  assign mul_b      = Fn3[1] ? {{XLEN{1'b0}}, OpB} : {{XLEN{OpB[XLEN-1]}}, OpB};
  assign prod       = mul_a * mul_b;
  assign mul_res    = (Fn3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign div_signed = ~Fn3[0];
  assign abs_a      = (div_signed & OpA[XLEN-1]) ? -OpA : OpA;
  assign abs_b      = (div_signed & OpB[XLEN-1]) ? -OpB : OpB;
  assign min_val    = {1'b1, {(XLEN-1){1'b0}}};
  assign div_by_zero = (OpB == '0);
  assign div_ovf    = div_signed & (OpA == min_val) & (OpB == '1);
  assign short_res  = div_by_zero ? (Fn3[1] ? OpA : '1) : (Fn3[1] ? '0 : OpA);

  assign rem_sh     = {rem_q, quo_q[XLEN-1]};
  assign quo_fix    = neg_q_q ? -quo_q : quo_q;
  assign rem_fix    = neg_r_q ? -rem_q : rem_q;
`else
  logic unused_fn7b0;
  assign unused_fn7b0 = Fn7b0;
`endif

  always_comb begin
    base_res = '0;
    case (Fn3)
      3'b000:  base_res = f7b5_eff ? OpA - OpB : OpA + OpB;
      3'b001:  base_res = OpA << shamt;
      3'b010:  base_res = {{(XLEN-1){1'b0}}, $signed(OpA) < $signed(OpB)};
      3'b011:  base_res = {{(XLEN-1){1'b0}}, OpA < OpB};
      3'b100:  base_res = OpA ^ OpB;
      3'b101:  base_res = f7b5_eff ? sra_res : OpA >> shamt;
      3'b110:  base_res = OpA | OpB;
      default: base_res = OpA & OpB;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (AluOp)
      2'b00:   alu_res = OpA + OpB;
      2'b01:   alu_res = OpA - OpB;
      2'b11:   alu_res = OpB;
      default: alu_res = base_res;
    endcase
`ifdef MEXT_EN
    if (m_sel) alu_res = Fn3[2] ? short_res : mul_res;
`endif
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
`ifdef MEXT_EN
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    is_rem_d = is_rem_q;
`endif
    if (Flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_DONE: if (OutReady) state_d = S_IDLE;
`ifdef MEXT_EN
        S_DIV: begin
          // Restoring division, one quotient bit per cycle, MSB first.
          if (rem_sh >= {1'b0, dvs_q}) begin
            rem_d = rem_sh[XLEN-1:0] - dvs_q;
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + SHW'(1);
          if (&cnt_q) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = is_rem_q ? rem_fix : quo_fix;
          state_d  = S_DONE;
        end
`endif
        default: ;
      endcase

      if (accept) begin
        state_d  = S_DONE;
        result_d = alu_res;
        cnt_d    = '0;
`ifdef MEXT_EN
        if (div_sel & ~div_by_zero & ~div_ovf) begin
          state_d  = S_DIV;
          result_d = result_q;
          quo_d    = abs_a;
          rem_d    = '0;
          dvs_d    = abs_b;
          neg_q_d  = div_signed & (OpA[XLEN-1] ^ OpB[XLEN-1]);
          neg_r_d  = div_signed & OpA[XLEN-1];
          is_rem_d = Fn3[1];
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef MEXT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      is_rem_q <= is_rem_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb/tb_alu_exec_seq.sv - scoreboard bench for alu_exec_seq (XLEN=32)
// Division/multiply vectors are active only when MEXT_EN is defined.
module tb_alu_exec_seq;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n, Flush, InValid, OutReady;
  logic [1:0]  AluOp;
  logic [2:0]  Fn3;
  logic        Fn7b5, Fn7b0, LastBit;
  logic [31:0] OpA, OpB;
  logic        InReady, OutValid, Zero;
  logic [31:0] Result;

  alu_exec_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .AluOp(AluOp), .Fn3(Fn3), .Fn7b5(Fn7b5), .Fn7b0(Fn7b0), .LastBit(LastBit),
    .OpA(OpA), .OpB(OpB), .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .Zero(Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  bit          head_seen = 1'b0;
  logic [31:0] last_exp = 32'd0;
  logic [31:0] held;
  logic [31:0] x_exp;
  int          x_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Latency counts edges with the accept edge as edge 1.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (OutValid && sb.size() > 0 && !head_seen) begin
        chk({sb[0].nm, "_latency"}, 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
        head_seen = 1'b1;
      end
      if (OutValid && OutReady) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: got 0x%08h expected no output", Result);
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_result"}, Result, e.res);
          chk({e.nm, "_zero"}, {31'd0, Zero}, {31'd0, e.res == 32'd0});
          head_seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [1:0] op, input logic [2:0] f3,
                       input logic f5, input logic f0, input logic lb,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ex, input int lat, input bit push);
    int n;
    @(negedge clk);
    AluOp = op; Fn3 = f3; Fn7b5 = f5; Fn7b0 = f0; LastBit = lb;
    OpA = a; OpB = b; InValid = 1'b1;
    #1;
    n = 0;
    while (!InReady && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!InReady) begin
      checks++;
      fails++;
      $display("FAIL %s_accept: got InReady=0 expected InReady=1 within 200 cycles", nm);
      InValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    InValid = 1'b0;
    if (push) begin
      sb.push_back('{nm, ex, lat, cyc});
      last_exp = ex;
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    AluOp = 2'b00; Fn3 = 3'b000; Fn7b5 = 1'b0; Fn7b0 = 1'b0; LastBit = 1'b0;
    OpA = 32'd0; OpB = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_inready",  {31'd0, InReady},  32'd1);
    chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
    chk("rst_result",   Result,            32'd0);
    chk("rst_zero",     {31'd0, Zero},     32'd1);
    rst_n = 1'b1;

    issue("sub_5_7",   2'b01, 3'b000, 0, 0, 0, 32'd5,         32'd7,        32'hFFFF_FFFE, 1, 1);
    issue("srai",      2'b10, 3'b101, 1, 0, 1, 32'h8000_0000, 32'd4,        32'hF800_0000, 1, 1);
    issue("addi_f5",   2'b10, 3'b000, 1, 0, 1, 32'h8000_0000, 32'd4,        32'h8000_0004, 1, 1);
    issue("sub_dec",   2'b10, 3'b000, 1, 0, 0, 32'd10,        32'd3,        32'd7,         1, 1);
    issue("sll_mask",  2'b10, 3'b001, 0, 0, 0, 32'd1,         32'h21,       32'd2,         1, 1);
    issue("slt",       2'b10, 3'b010, 0, 0, 0, 32'hFFFF_FFFF, 32'd1,        32'd1,         1, 1);
    issue("sltu",      2'b10, 3'b011, 0, 0, 0, 32'hFFFF_FFFF, 32'd1,        32'd0,         1, 1);
    issue("xor",       2'b10, 3'b100, 0, 0, 0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1, 1);
    issue("srl",       2'b10, 3'b101, 0, 0, 0, 32'h8000_0000, 32'd4,        32'h0800_0000, 1, 1);
    issue("sra_reg",   2'b10, 3'b101, 1, 0, 0, 32'h8000_0000, 32'd4,        32'hF800_0000, 1, 1);
    issue("or",        2'b10, 3'b110, 0, 0, 0, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1, 1);
    issue("pass_b",    2'b11, 3'b000, 0, 0, 0, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1, 1);
    issue("add_wrap",  2'b00, 3'b000, 0, 0, 0, 32'hFFFF_FFFF, 32'd1,        32'd0,         1, 1);
    issue("slli_f0",   2'b10, 3'b001, 0, 1, 1, 32'd3,         32'd4,        32'd48,        1, 1);
`ifdef MEXT_EN
    x_exp = 32'd12; x_lat = 1;
`else
    x_exp = 32'd7;  x_lat = 1;
`endif
    issue("mul_or_add", 2'b10, 3'b000, 0, 1, 0, 32'd3, 32'd4, x_exp, x_lat, 1);
`ifdef MEXT_EN
    x_exp = 32'd1;  x_lat = XLEN + 2;
`else
    x_exp = 32'd6;  x_lat = 1;
`endif
    issue("div_or_xor", 2'b10, 3'b100, 0, 1, 0, 32'd5, 32'd3, x_exp, x_lat, 1);

`ifdef MEXT_EN
    issue("mulh",      2'b10, 3'b001, 0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1, 1);
    issue("mulhu",     2'b10, 3'b011, 0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 1);
    issue("mulhsu",    2'b10, 3'b010, 0, 1, 0, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1, 1);
    issue("divu_100_7", 2'b10, 3'b101, 0, 1, 0, 32'd100, 32'd7, 32'd14, XLEN + 2, 1);
    @(negedge clk);
    chk("div_busy_inready", {31'd0, InReady}, 32'd0);
    issue("rem_m7_2",  2'b10, 3'b110, 0, 1, 0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, XLEN + 2, 1);
    issue("div_m7_2",  2'b10, 3'b100, 0, 1, 0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, XLEN + 2, 1);
    issue("remu_100_7", 2'b10, 3'b111, 0, 1, 0, 32'd100,      32'd7,         32'd2,         XLEN + 2, 1);
    issue("div_by0",   2'b10, 3'b100, 0, 1, 0, 32'd42,        32'd0,         32'hFFFF_FFFF, 1, 1);
    issue("rem_by0",   2'b10, 3'b110, 0, 1, 0, 32'd42,        32'd0,         32'd42,        1, 1);
    issue("div_ovf",   2'b10, 3'b100, 0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
    issue("rem_ovf",   2'b10, 3'b110, 0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1);
`endif
    drain("vectors");

    OutReady = 1'b0;
    issue("and_bp", 2'b10, 3'b111, 0, 0, 0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result",   Result,             32'h0000_F000);
      chk("bp_outvalid", {31'd0, OutValid},  32'd1);
      chk("bp_inready",  {31'd0, InReady},   32'd0);
    end
    OutReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_released_outvalid", {31'd0, OutValid}, 32'd0);
    drain("backpressure");

`ifdef MEXT_EN
    held = last_exp;
    issue("div_flushed", 2'b10, 3'b100, 0, 1, 0, 32'd1000, 32'd3, 32'd0, 0, 0);
    repeat (8) @(negedge clk);
`else
    held = 32'd7;
    OutReady = 1'b0;
    issue("add_flushed", 2'b00, 3'b000, 0, 0, 0, 32'd3, 32'd4, 32'd0, 0, 0);
`endif
    @(negedge clk);
    Flush = 1'b1;
    InValid = 1'b1; AluOp = 2'b00; Fn7b0 = 1'b0; OpA = 32'd5; OpB = 32'd5;
    @(negedge clk);
    chk("flush_outvalid", {31'd0, OutValid}, 32'd0);
    chk("flush_inready",  {31'd0, InReady},  32'd1);
    chk("flush_result",   Result,            held);
    @(negedge clk);
    chk("flush_req_outvalid", {31'd0, OutValid}, 32'd0);
    chk("flush_req_result",   Result,            held);
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    repeat (XLEN + 4) @(negedge clk);
    issue("add_after_flush", 2'b00, 3'b000, 0, 0, 0, 32'd1, 32'd1, 32'd2, 1, 1);
    drain("flush");

`ifdef MEXT_EN
    issue("div_reset", 2'b10, 3'b101, 0, 1, 0, 32'd100, 32'd7, 32'd0, 0, 0);
`else
    OutReady = 1'b0;
    issue("add_reset", 2'b00, 3'b000, 0, 0, 0, 32'd9, 32'd9, 32'd0, 0, 0);
`endif
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_inready",  {31'd0, InReady},  32'd1);
    chk("arst_outvalid", {31'd0, OutValid}, 32'd0);
    chk("arst_result",   Result,            32'd0);
    chk("arst_zero",     {31'd0, Zero},     32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    OutReady = 1'b1;
    repeat (XLEN + 6) @(negedge clk);
    chk("post_reset_outvalid", {31'd0, OutValid}, 32'd0);
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
